// File: rtl/imem_loader_if.sv
// Handshake and memory-write bus between the program-byte source, the loader and the memory.
// The master modport is the loader side; the slave modport is the source/memory/CPU side.
interface imem_loader_if;
    logic        start;
    logic [15:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error
    );

    modport slave (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to memory, then releases the CPU.
// Optional trailer checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Where the FSM goes once all words are written (or immediately for an empty program).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_FINAL = ST_CHECK;
`else
    localparam state_t ST_FINAL = ST_DONE;
`endif

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   index_r;
    logic [1:0]              lane_r;
    logic [15:0]             word_count_r;
    logic [23:0]             shift_r;
    logic [31:0]             word_s;
    logic                    accept_s;
    logic                    start_acc_s;
    logic                    overflow_s;
    logic                    last_word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]             checksum_r;
`endif

    function automatic logic takes_bytes(input state_t s);
        logic r;
        case (s)
            ST_LOAD:  r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: r = 1'b1;
`endif
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_busy(input state_t s);
        logic r;
        case (s)
            ST_LOAD, ST_WRITE: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK:          r = 1'b1;
`endif
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    assign accept_s    = bus.byte_valid && bus.byte_ready;
    assign word_s      = {bus.byte_data, shift_r};
    assign overflow_s  = {17'd0, bus.word_count} > CAPACITY;
    assign last_word_s = ({{(32-ADDR_WIDTH){1'b0}}, index_r} + 32'd1) == {16'd0, word_count_r};
    assign start_acc_s = bus.start &&
                         ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));

    // Next-state decision for the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (!start_acc_s) begin
                    state_nxt_s = state_r;
                end else if (overflow_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (bus.word_count == 16'd0) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept_s && (lane_r == 2'd3)) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s && (lane_r == 2'd3)) begin
                    state_nxt_s = (word_s == checksum_r) ? ST_DONE : ST_ERROR;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs (outputs decoded from the next state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            index_r        <= '0;
            lane_r         <= 2'd0;
            word_count_r   <= 16'd0;
            shift_r        <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_r     <= 32'd0;
`endif
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= BASE_ADDR;
            bus.mem_wdata  <= 32'd0;
            bus.cpu_reset  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            bus.byte_ready <= takes_bytes(state_nxt_s);
            bus.mem_we     <= (state_nxt_s == ST_WRITE);
            bus.cpu_reset  <= (state_nxt_s != ST_DONE);
            bus.busy       <= is_busy(state_nxt_s);
            bus.done       <= (state_nxt_s == ST_DONE);
            bus.error      <= (state_nxt_s == ST_ERROR);

            if (start_acc_s) begin
                word_count_r <= bus.word_count;
                if (!overflow_s) begin
                    index_r    <= '0;
                    lane_r     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_r <= 32'd0;
`endif
                end else begin
                    index_r    <= index_r;
                end
            end else if (accept_s) begin
                lane_r <= lane_r + 2'd1;
                case (lane_r)
                    2'd0:    shift_r[7:0]   <= bus.byte_data;
                    2'd1:    shift_r[15:8]  <= bus.byte_data;
                    2'd2:    shift_r[23:16] <= bus.byte_data;
                    default: begin
                        // Only program words go to memory; the checksum trailer is compared, not stored.
                        if (state_r == ST_LOAD) begin
                            bus.mem_wdata <= word_s;
                            bus.mem_addr  <= BASE_ADDR + (32'(index_r) << 2);
                        end else begin
                            bus.mem_wdata <= bus.mem_wdata;
                        end
                    end
                endcase
            end else if (state_r == ST_WRITE) begin
                index_r    <= index_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
                checksum_r <= checksum_r + bus.mem_wdata;
`endif
            end else begin
                index_r <= index_r;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus randomized gap/noise loads against a word-list model.
// Follows the IMEM_LOADER_CHECKSUM_EN build of the design when that macro is defined.
module tb_imem_loader;
    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'd0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_loader_if ifc();

    imem_loader #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_words[$];

    // Record every cycle in which the write strobe is high.
    always @(negedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            obs_addr.push_back(ifc.mem_addr);
            obs_data.push_back(ifc.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_byte_ready", {31'd0, ifc.byte_ready}, 32'd0);
        chk("rst_mem_we",     {31'd0, ifc.mem_we},     32'd0);
        chk("rst_mem_addr",   ifc.mem_addr,            BASE);
        chk("rst_mem_wdata",  ifc.mem_wdata,           32'd0);
        chk("rst_cpu_reset",  {31'd0, ifc.cpu_reset},  32'd1);
        chk("rst_busy",       {31'd0, ifc.busy},       32'd0);
        chk("rst_done",       {31'd0, ifc.done},       32'd0);
        chk("rst_error",      {31'd0, ifc.error},      32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] wc);
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.word_count = wc;
        @(negedge clk);
        ifc.start      = 1'b0;
        ifc.word_count = 16'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit noisy);
        int n;
        if (noisy) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                ifc.byte_valid = 1'b0;
                ifc.byte_data  = 8'($urandom);
                ifc.start      = ($urandom_range(0, 2) == 0);
                ifc.word_count = 16'($urandom_range(0, 5));
                @(negedge clk);
            end
            ifc.start = 1'b0;
        end
        ifc.byte_valid = 1'b1;
        ifc.byte_data  = b;
        n = 0;
        while (ifc.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("byte_ready_timeout", {31'd0, n < 50}, 32'd1);
        @(negedge clk);
        ifc.byte_valid = 1'b0;
    endtask

    // Sends exp_words (and a trailer when checksumming), then checks writes and final status.
    task automatic run_load(input logic [15:0] wc, input bit noisy, input logic [31:0] trailer);
        logic [31:0] sum;
        logic        exp_done;
        int          n;
        obs_addr.delete();
        obs_data.delete();
        do_start(wc);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("cpu_reset_held", {31'd0, ifc.cpu_reset}, 32'd1);
`else
        chk("cpu_reset_held", {31'd0, ifc.cpu_reset}, {31'd0, wc != 16'd0});
`endif
        sum = 32'd0;
        for (int i = 0; i < exp_words.size(); i++) begin
            sum = sum + exp_words[i];
            for (int k = 0; k < 4; k++) send_byte(exp_words[i][8*k +: 8], noisy);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) send_byte(trailer[8*k +: 8], noisy);
        exp_done = (trailer == sum);
`else
        exp_done = 1'b1;
`endif
        n = 0;
        while (ifc.done !== 1'b1 && ifc.error !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("finish_timeout", {31'd0, n < 20}, 32'd1);
        @(negedge clk);
        chk("write_count", obs_addr.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < obs_addr.size(); i++) begin
            chk("write_addr", obs_addr[i], BASE + 32'(4 * i));
            chk("write_data", obs_data[i], exp_words[i]);
        end
        chk("done",       {31'd0, ifc.done},       {31'd0, exp_done});
        chk("error",      {31'd0, ifc.error},      {31'd0, !exp_done});
        chk("cpu_reset",  {31'd0, ifc.cpu_reset},  {31'd0, !exp_done});
        chk("busy_end",   {31'd0, ifc.busy},       32'd0);
        chk("ready_end",  {31'd0, ifc.byte_ready}, 32'd0);
    endtask

    function automatic logic [31:0] sum_words();
        logic [31:0] s = 32'd0;
        foreach (exp_words[i]) s = s + exp_words[i];
        return s;
    endfunction

    initial begin
        reset          = 1'b1;
        ifc.start      = 1'b0;
        ifc.word_count = 16'd0;
        ifc.byte_valid = 1'b0;
        ifc.byte_data  = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulse_reset();

        // Directed two-word program with the reference checksum trailer.
        exp_words = '{32'h1234_5678, 32'hDEAD_BEEF};
        run_load(16'd2, 1'b0, 32'hF0E2_1567);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load(16'd2, 1'b0, 32'h0000_0000);
`endif

        // Oversized program is rejected immediately.
        obs_addr.delete();
        do_start(16'((1 << AW) + 1));
        chk("ovf_error",     {31'd0, ifc.error},      32'd1);
        chk("ovf_cpu_reset", {31'd0, ifc.cpu_reset},  32'd1);
        chk("ovf_busy",      {31'd0, ifc.busy},       32'd0);
        chk("ovf_ready",     {31'd0, ifc.byte_ready}, 32'd0);
        repeat (4) @(negedge clk);
        chk("ovf_no_write",  obs_addr.size(),         32'd0);

        // Random three-word programs, with gaps and stray starts, then gap-free.
        repeat (3) begin
            exp_words = '{$urandom, $urandom, $urandom};
            run_load(16'd3, 1'b1, sum_words());
            run_load(16'd3, 1'b0, sum_words());
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_load(16'd3, 1'b1, sum_words() + 32'd1);
`endif

        // Empty program.
        exp_words.delete();
        run_load(16'd0, 1'b0, 32'd0);

        // Reset in the middle of the second word abandons the load.
        exp_words = '{$urandom, $urandom};
        obs_addr.delete();
        obs_data.delete();
        do_start(16'd2);
        for (int k = 0; k < 4; k++) send_byte(exp_words[0][8*k +: 8], 1'b0);
        for (int k = 0; k < 2; k++) send_byte(exp_words[1][8*k +: 8], 1'b0);
        pulse_reset();
        repeat (5) @(negedge clk);
        chk("midrst_writes", obs_addr.size(), 32'd1);
        chk("midrst_state_done", {31'd0, ifc.done}, 32'd0);
        exp_words = '{$urandom, $urandom};
        run_load(16'd2, 1'b1, sum_words());

        // Exactly full memory is accepted.
        exp_words.delete();
        for (int i = 0; i < (1 << AW); i++) exp_words.push_back($urandom);
        run_load(16'(1 << AW), 1'b0, sum_words());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
